bcd_timebase_timer: RTL and testbench

Parametrised time base plus a two-field BCD minutes:seconds counter, successor to the fixed 100 MHz usec/msec/sec/min dividers and the loadable 60-counters. A single cascaded prescaler produces one-cycle usec/msec/sec strobes. A seconds/minutes BCD counter consumes the second strobe and counts up or down with load, clear, pause, a wrap strobe and a countdown-done flag. It sits between the board clock and the FND display and watch/stopwatch/timer control logic.

---
 rtl/bcd_timebase_timer.sv | 248 ++++++++++++++++++++++++
 tb/tb_bcd_timebase_timer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timebase_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bcd_timebase_timer
// Purpose  : Cascaded usec/msec/sec prescaler feeding a BCD mm:ss counter
//            with up/down count, load, clear, pause, wrap strobe and a
//            countdown-done flag.
// Options  : TIMER_AUTORELOAD_EN - countdown reloads the last loaded value at
//            00:00 and done becomes a one-cycle pulse. Undefined: the counter
//            stops at 00:00 with a sticky done.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_timebase_timer #(
    parameter int CLK_PER_USEC  = 100,
    parameter int USEC_PER_MSEC = 1000,
    parameter int MSEC_PER_SEC  = 1000,
    parameter int SEC_MOD       = 60,
    parameter int MIN_MOD       = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       mode_down,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min10,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       tick_usec,
    output logic       tick_msec,
    output logic       tick_sec,
    output logic       wrap,
    output logic       done
);

    localparam int c_US_W = $clog2(CLK_PER_USEC);
    localparam int c_MS_W = $clog2(USEC_PER_MSEC);
    localparam int c_S_W  = $clog2(MSEC_PER_SEC);

    localparam logic [c_US_W-1:0] c_US_LAST = c_US_W'(CLK_PER_USEC - 1);
    localparam logic [c_MS_W-1:0] c_MS_LAST = c_MS_W'(USEC_PER_MSEC - 1);
    localparam logic [c_S_W-1:0]  c_S_LAST  = c_S_W'(MSEC_PER_SEC - 1);

    // Largest legal field values, pre-encoded as two BCD digits
    localparam logic [7:0] c_SEC_MAX = {4'((SEC_MOD - 1) / 10), 4'((SEC_MOD - 1) % 10)};
    localparam logic [7:0] c_MIN_MAX = {4'((MIN_MOD - 1) / 10), 4'((MIN_MOD - 1) % 10)};

    // Two-digit BCD increment; the caller handles the modulus boundary
    function automatic logic [7:0] bcd_inc(input logic [7:0] f);
        if (f[3:0] == 4'd9) bcd_inc = {f[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {f[7:4], f[3:0] + 4'd1};
    endfunction

    // Two-digit BCD decrement; the caller never passes 00
    function automatic logic [7:0] bcd_dec(input logic [7:0] f);
        if (f[3:0] == 4'd0) bcd_dec = {f[7:4] - 4'd1, 4'd9};
        else                bcd_dec = {f[7:4], f[3:0] - 4'd1};
    endfunction

    // Out-of-range or non-BCD load values saturate to the field maximum
    function automatic logic [7:0] sanitize(input logic [3:0] d10, input logic [3:0] d1,
                                            input logic [7:0] max_bcd, input int modv);
        int v;
        v = 10 * int'(d10) + int'(d1);
        if (d10 > 4'd9 || d1 > 4'd9 || v >= modv) sanitize = max_bcd;
        else                                      sanitize = {d10, d1};
    endfunction

    logic [c_US_W-1:0] usec_cnt_q, usec_cnt_d;
    logic [c_MS_W-1:0] msec_cnt_q, msec_cnt_d;
    logic [c_S_W-1:0]  sec_cnt_q,  sec_cnt_d;
    logic              tick_usec_q, tick_usec_d;
    logic              tick_msec_q, tick_msec_d;
    logic              tick_sec_q,  tick_sec_d;
    logic              usec_wrap, msec_wrap, sec_wrap;

    logic [7:0]        sec_q, sec_d;
    logic [7:0]        min_q, min_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic [7:0]        load_sec, load_min;
    logic              at_zero, at_one;
    logic [7:0]        dn_sec, dn_min;

`ifdef TIMER_AUTORELOAD_EN
    logic [7:0]        reload_sec_q, reload_sec_d;
    logic [7:0]        reload_min_q, reload_min_d;
`endif

    // Prescaler: each stage advances on the wrap of the stage below, so all
    // three strobes line up on the same edge when they coincide
    always_comb begin
        usec_wrap  = (usec_cnt_q == c_US_LAST);
        usec_cnt_d = usec_wrap ? '0 : usec_cnt_q + 1'b1;

        msec_wrap  = usec_wrap && (msec_cnt_q == c_MS_LAST);
        msec_cnt_d = msec_cnt_q;
        if (usec_wrap) msec_cnt_d = msec_wrap ? '0 : msec_cnt_q + 1'b1;

        sec_wrap   = msec_wrap && (sec_cnt_q == c_S_LAST);
        sec_cnt_d  = sec_cnt_q;
        if (msec_wrap) sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + 1'b1;

        tick_usec_d = usec_wrap;
        tick_msec_d = msec_wrap;
        tick_sec_d  = sec_wrap;
        // Restart the second after a set so the first second is not short
        if (clear || load) begin
            sec_cnt_d  = '0;
            tick_sec_d = 1'b0;
        end
    end

    // BCD counter next state: clear beats load beats the sec strobe
    always_comb begin
        sec_d  = sec_q;
        min_d  = min_q;
        wrap_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        done_d       = 1'b0;
        reload_sec_d = reload_sec_q;
        reload_min_d = reload_min_q;
`else
        done_d = done_q;
`endif
        load_sec = sanitize(set_sec10, set_sec1, c_SEC_MAX, SEC_MOD);
        load_min = sanitize(set_min10, set_min1, c_MIN_MAX, MIN_MOD);
        at_zero  = (sec_q == 8'h00) && (min_q == 8'h00);
        at_one   = (sec_q == 8'h01) && (min_q == 8'h00);

        // Down step for a non-terminal value: borrow from minutes at sec 00
        if (sec_q == 8'h00) begin
            dn_sec = c_SEC_MAX;
            dn_min = bcd_dec(min_q);
        end else begin
            dn_sec = bcd_dec(sec_q);
            dn_min = min_q;
        end

        if (clear) begin
            sec_d  = 8'h00;
            min_d  = 8'h00;
            done_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_sec_d = 8'h00;
            reload_min_d = 8'h00;
`endif
        end else if (load) begin
            sec_d  = load_sec;
            min_d  = load_min;
            done_d = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_sec_d = load_sec;
            reload_min_d = load_min;
`endif
        end else if (run && tick_sec_q) begin
            if (!mode_down) begin
                if (sec_q == c_SEC_MAX) begin
                    sec_d = 8'h00;
                    if (min_q == c_MIN_MAX) begin
                        min_d  = 8'h00;
                        wrap_d = 1'b1;
                    end else begin
                        min_d = bcd_inc(min_q);
                    end
                end else begin
                    sec_d = bcd_inc(sec_q);
                end
            end else begin
`ifdef TIMER_AUTORELOAD_EN
                // Arriving at (or sitting on) 00:00 reloads instead
                if (at_zero || at_one) begin
                    sec_d  = reload_sec_q;
                    min_d  = reload_min_q;
                    done_d = 1'b1;
                end else begin
                    sec_d = dn_sec;
                    min_d = dn_min;
                end
`else
                // Once done, the countdown is parked until clear/load
                if (!done_q) begin
                    if (at_zero || at_one) begin
                        sec_d  = 8'h00;
                        min_d  = 8'h00;
                        done_d = 1'b1;
                    end else begin
                        sec_d = dn_sec;
                        min_d = dn_min;
                    end
                end
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            usec_cnt_q  <= '0;
            msec_cnt_q  <= '0;
            sec_cnt_q   <= '0;
            tick_usec_q <= 1'b0;
            tick_msec_q <= 1'b0;
            tick_sec_q  <= 1'b0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_sec_q <= 8'h00;
            reload_min_q <= 8'h00;
`endif
        end else begin
            usec_cnt_q  <= usec_cnt_d;
            msec_cnt_q  <= msec_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            tick_usec_q <= tick_usec_d;
            tick_msec_q <= tick_msec_d;
            tick_sec_q  <= tick_sec_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
`ifdef TIMER_AUTORELOAD_EN
            reload_sec_q <= reload_sec_d;
            reload_min_q <= reload_min_d;
`endif
        end
    end

    assign sec1      = sec_q[3:0];
    assign sec10     = sec_q[7:4];
    assign min1      = min_q[3:0];
    assign min10     = min_q[7:4];
    assign tick_usec = tick_usec_q;
    assign tick_msec = tick_msec_q;
    assign tick_sec  = tick_sec_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timebase_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bcd_timebase_timer
// Purpose  : Self-checking bench for bcd_timebase_timer (2/2/2 prescale,
//            60/60 fields). Honours TIMER_AUTORELOAD_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timebase_timer;

    localparam int TB_CPU = 2;
    localparam int TB_UPM = 2;
    localparam int TB_MPS = 2;
    localparam int TB_SM  = 60;
    localparam int TB_MM  = 60;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, mode_down, clear, load;
    logic [3:0] set_sec1, set_sec10, set_min1, set_min10;
    logic [3:0] sec1, sec10, min1, min10;
    logic       tick_usec, tick_msec, tick_sec, wrap, done;

    bcd_timebase_timer #(
        .CLK_PER_USEC (TB_CPU),
        .USEC_PER_MSEC(TB_UPM),
        .MSEC_PER_SEC (TB_MPS),
        .SEC_MOD      (TB_SM),
        .MIN_MOD      (TB_MM)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .mode_down(mode_down),
        .clear(clear), .load(load),
        .set_sec1(set_sec1), .set_sec10(set_sec10),
        .set_min1(set_min1), .set_min10(set_min10),
        .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
        .tick_usec(tick_usec), .tick_msec(tick_msec), .tick_sec(tick_sec),
        .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (whole-second arithmetic) ----------------
    int m_cyc, m_ms_cnt;
    int e_sec, e_min, rl_sec, rl_min;
    bit e_tu, e_tm, e_ts, e_wrap, e_done;

    function automatic int san(input int d10, input int d1, input int modv);
        if (d10 > 9 || d1 > 9 || d10 * 10 + d1 >= modv) return modv - 1;
        return d10 * 10 + d1;
    endfunction

    function automatic logic [15:0] to_bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_ms_cnt = 0;
        e_sec = 0; e_min = 0; rl_sec = 0; rl_min = 0;
        e_tu = 0; e_tm = 0; e_ts = 0; e_wrap = 0; e_done = 0;
    endtask

    // Called right after each rising edge with the inputs the DUT sampled
    task automatic model_edge();
        int tot;
        bit nd, nw, sw;
        if (!reset_n) begin
            model_reset();
        end else begin
            nw = 0;
`ifdef TIMER_AUTORELOAD_EN
            nd = 0;
`else
            nd = e_done;
`endif
            if (clear) begin
                e_sec = 0; e_min = 0; nd = 0; rl_sec = 0; rl_min = 0;
            end else if (load) begin
                e_sec = san(int'(set_sec10), int'(set_sec1), TB_SM);
                e_min = san(int'(set_min10), int'(set_min1), TB_MM);
                rl_sec = e_sec; rl_min = e_min; nd = 0;
            end else if (run && e_ts) begin
                tot = e_min * TB_SM + e_sec;
                if (!mode_down) begin
                    tot++;
                    if (tot == TB_SM * TB_MM) begin tot = 0; nw = 1; end
                end else begin
`ifdef TIMER_AUTORELOAD_EN
                    if (tot <= 1) begin tot = rl_min * TB_SM + rl_sec; nd = 1; end
                    else tot--;
`else
                    if (!e_done) begin
                        if (tot > 0) tot--;
                        if (tot == 0) nd = 1;
                    end
`endif
                end
                e_min = tot / TB_SM;
                e_sec = tot % TB_SM;
            end
            e_done = nd;
            e_wrap = nw;
            // strobes: cycle count since reset, sec stage restarted by sets
            m_cyc++;
            e_tu = (m_cyc % TB_CPU) == 0;
            e_tm = (m_cyc % (TB_CPU * TB_UPM)) == 0;
            sw = 0;
            if (e_tm) begin
                m_ms_cnt++;
                if (m_ms_cnt == TB_MPS) begin m_ms_cnt = 0; sw = 1; end
            end
            if (clear || load) begin m_ms_cnt = 0; sw = 0; end
            e_ts = sw;
        end
    endtask

    function automatic logic [15:0] dut_val();
        return {min10, min1, sec10, sec1};
    endfunction

    task automatic check_all();
        chk("tick_usec", tick_usec, e_tu);
        chk("tick_msec", tick_msec, e_tm);
        chk("tick_sec",  tick_sec,  e_ts);
        chk("value",     dut_val(), to_bcd(e_min, e_sec));
        chk("wrap",      wrap,      e_wrap);
        chk("done",      done,      e_done);
    endtask

    // One clock: edge, model update, then sample 1ns after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_sec_tick();
        int n = 0;
        while (!tick_sec && n < 40) begin step(); n++; end
        chk("sec_tick_wait", tick_sec, 1'b1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        bit          do_load;
        logic [15:0] set;
        bit          down;
        int          nticks;
        logic [15:0] exp;
        bit          exp_wrap;
        bit          exp_done;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input string nm, input bit ld, input logic [15:0] st, input bit dn,
                           input int nt, input logic [15:0] ex, input bit ew, input bit ed);
        vec_t v;
        v.name = nm; v.do_load = ld; v.set = st; v.down = dn;
        v.nticks = nt; v.exp = ex; v.exp_wrap = ew; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        reset_n = 1'b0; run = 0; mode_down = 0; clear = 0; load = 0;
        set_sec1 = 0; set_sec10 = 0; set_min1 = 0; set_min10 = 0;
        model_reset();

        add_vec("up_5958",   1, 16'h5958, 0, 1, 16'h5959, 0, 0);
        add_vec("up_wrap",   0, 16'h0000, 0, 1, 16'h0000, 1, 0);
        add_vec("dn_0002",   1, 16'h0002, 1, 1, 16'h0001, 0, 0);
`ifdef TIMER_AUTORELOAD_EN
        add_vec("dn_zero",   0, 16'h0000, 1, 1, 16'h0002, 0, 1);
        add_vec("dn_more5",  0, 16'h0000, 1, 5, 16'h0001, 0, 0);
`else
        add_vec("dn_zero",   0, 16'h0000, 1, 1, 16'h0000, 0, 1);
        add_vec("dn_more5",  0, 16'h0000, 1, 5, 16'h0000, 0, 1);
`endif
        add_vec("ld_0100",   1, 16'h0100, 1, 0, 16'h0100, 0, 0);
        add_vec("ld_7F65",   1, 16'h7F65, 0, 0, 16'h5959, 0, 0);
        add_vec("up_1234",   1, 16'h1234, 0, 1, 16'h1235, 0, 0);
        add_vec("dn_1235",   0, 16'h0000, 1, 1, 16'h1234, 0, 0);
        add_vec("dn_borrow", 1, 16'h0100, 1, 1, 16'h0059, 0, 0);
        add_vec("dn_ld0000", 1, 16'h0000, 1, 1, 16'h0000, 0, 1);
        add_vec("up_carry",  1, 16'h0959, 0, 1, 16'h1000, 0, 0);
        add_vec("ld_6060",   1, 16'h6060, 0, 0, 16'h5959, 0, 0);

        // reset state
        repeat (3) step();
        reset_n = 1'b1;

        // strobe periods after release
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("strobe_usec", tick_usec, (k % 2) == 0);
            chk("strobe_msec", tick_msec, (k % 4) == 0);
            chk("strobe_sec",  tick_sec,  (k % 8) == 0);
        end

        // table
        foreach (vecs[i]) begin
            run = 0;
            if (vecs[i].do_load) begin
                load = 1;
                {set_min10, set_min1, set_sec10, set_sec1} = vecs[i].set;
                step();
                load = 0;
            end
            mode_down = vecs[i].down;
            run = 1;
            for (int k = 0; k < vecs[i].nticks; k++) begin
                wait_sec_tick();
                step();
            end
            run = 0;
            chk({vecs[i].name, "_val"},  dut_val(), vecs[i].exp);
            chk({vecs[i].name, "_wrap"}, wrap,      vecs[i].exp_wrap);
            chk({vecs[i].name, "_done"}, done,      vecs[i].exp_done);
        end

        // clear and load together: clear wins
        {set_min10, set_min1, set_sec10, set_sec1} = 16'h1234;
        clear = 1; load = 1;
        step();
        clear = 0; load = 0;
        chk("clear_over_load", dut_val(), 16'h0000);

        // load coinciding with a sec strobe, then a full-length second
        mode_down = 0; run = 1;
        wait_sec_tick();
        {set_min10, set_min1, set_sec10, set_sec1} = 16'h2345;
        load = 1;
        step();
        load = 0;
        chk("load_over_tick", dut_val(), 16'h2345);
        begin
            int cnt = 0;
            while (!tick_sec && cnt < 50) begin step(); cnt++; end
            chk("full_second", cnt, 7);
        end
        step();
        chk("after_full_second", dut_val(), 16'h2346);

        // asynchronous reset pulse between edges at 12:34
        run = 0;
        {set_min10, set_min1, set_sec10, set_sec1} = 16'h1234;
        load = 1;
        step();
        load = 0;
        step();
        chk("pre_reset_val", dut_val(), 16'h1234);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_val", dut_val(), 16'h0000);
        chk("async_reset_flags", {tick_usec, tick_msec, tick_sec, wrap, done}, 5'b0);
        model_reset();
        #2 reset_n = 1'b1;
        step();
        chk("rel_usec_1", tick_usec, 1'b0);
        step();
        chk("rel_usec_2", tick_usec, 1'b1);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            run   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) mode_down = ~mode_down;
            clear = ($urandom_range(0, 199) == 0);
            load  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                set_min10 = 4'($urandom_range(0, 15)); set_min1 = 4'($urandom_range(0, 15));
                set_sec10 = 4'($urandom_range(0, 15)); set_sec1 = 4'($urandom_range(0, 15));
            end else begin
                set_min10 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 5));
                set_min1  = 4'($urandom_range(0, 9));
                set_sec10 = 4'($urandom_range(0, 5));
                set_sec1  = 4'($urandom_range(0, 9));
            end
            step();
        end
        clear = 0; load = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
